// File: rtl/vga_timing_pattern.sv
// vga_timing_pattern: VGA sync/timing generator with four built-in test
// patterns (solid, colour bars, checker, grid). Counters advance on a pixel
// strobe derived from OSC_50; all video outputs are registered one strobe
// behind the counter state so syncs, DE, X/Y and RGB stay aligned.
// Optional macro VGA_BORDER_EN forces a one-pixel white border on the
// active area in every mode.
module vga_timing_pattern #(
  parameter int H_ACT     = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACT     = 480,
  parameter int V_FRONT   = 11,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 31,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int RGB_W     = 8,
  parameter int PIX_DIV   = 2,
  parameter int CHK_LOG2  = 5,
  parameter int GRID_LOG2 = 4
) (
  input  logic               OSC_50,
  input  logic               RST,
  input  logic [1:0]         MODE,
  input  logic [3*RGB_W-1:0] COLOR,
  output logic               PIX_EN,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_DE,
  output logic [10:0]        X,
  output logic [10:0]        Y,
  output logic [RGB_W-1:0]   VGA_R,
  output logic [RGB_W-1:0]   VGA_G,
  output logic [RGB_W-1:0]   VGA_B,
  output logic [15:0]        FRAME_CNT
);

  localparam int   H_TOTAL = H_ACT + H_FRONT + H_SYNC + H_BACK;
  localparam int   V_TOTAL = V_ACT + V_FRONT + V_SYNC + V_BACK;
  localparam int   HS_BEG  = H_ACT + H_FRONT;
  localparam int   HS_END  = HS_BEG + H_SYNC;
  localparam int   VS_BEG  = V_ACT + V_FRONT;
  localparam int   VS_END  = VS_BEG + V_SYNC;
  localparam logic HS_ON   = (HS_POL != 0);
  localparam logic VS_ON   = (VS_POL != 0);
  localparam int   PW      = 3 * RGB_W;

  logic          div;
  logic          pix_en;
  logic [10:0]   h, v;
  logic [1:0]    mode_q;
  logic [PW-1:0] color_q;

  logic          frame_start, h_last, v_last;
  logic          active, hs_in, vs_in;
  logic [1:0]    mode_cur;
  logic [PW-1:0] color_cur;
  logic [PW-1:0] pix;
  logic [2:0]    bar;

  assign pix_en      = ~div;
  assign PIX_EN      = pix_en;
  assign frame_start = (h == '0) && (v == '0);
  assign h_last      = (h == 11'(H_TOTAL - 1));
  assign v_last      = (v == 11'(V_TOTAL - 1));
  assign active      = (h < 11'(H_ACT)) && (v < 11'(V_ACT));
  assign hs_in       = (h >= 11'(HS_BEG)) && (h < 11'(HS_END));
  assign vs_in       = (v >= 11'(VS_BEG)) && (v < 11'(VS_END));

  // The first pixel of a frame uses MODE/COLOR live so the sampled value
  // already governs pixel (0,0); the rest of the frame uses the latch.
  assign mode_cur  = frame_start ? MODE  : mode_q;
  assign color_cur = frame_start ? COLOR : color_q;

  // Pixel strobe: toggling divider for PIX_DIV=2, held at 0 (strobe always high) for PIX_DIV=1
  always_ff @(posedge OSC_50) begin
    if (RST) div <= 1'b0;
    else     div <= (PIX_DIV == 2) ? ~div : 1'b0;
  end

  // Horizontal/vertical raster counters
  always_ff @(posedge OSC_50) begin
    if (RST) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + 11'd1;
      end else begin
        h <= h + 11'd1;
      end
    end
  end

  // Latch MODE/COLOR once per frame at the (0,0) update
  always_ff @(posedge OSC_50) begin
    if (RST) begin
      mode_q  <= '0;
      color_q <= '0;
    end else if (pix_en && frame_start) begin
      mode_q  <= MODE;
      color_q <= COLOR;
    end
  end

  // Completed-frame counter, bumped as V wraps to 0
  always_ff @(posedge OSC_50) begin
    if (RST)                           FRAME_CNT <= '0;
    else if (pix_en && h_last && v_last) FRAME_CNT <= FRAME_CNT + 16'd1;
  end

  // Colour bar index floor(h*8/H_ACT) using constant thresholds instead of a divider
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if ((14'(h) << 3) >= 14'(k * H_ACT)) bar = 3'(k);
  end

  // Pattern colour for the current counter position
  always_comb begin
    pix = '0;
    case (mode_cur)
      2'd0:    pix = color_cur;
      2'd1:    pix = {{RGB_W{~bar[1]}}, {RGB_W{~bar[2]}}, {RGB_W{~bar[0]}}};
      2'd2:    pix = (h[CHK_LOG2] ^ v[CHK_LOG2]) ? '0 : color_cur;
      default: pix = ((h[GRID_LOG2-1:0] == '0) || (v[GRID_LOG2-1:0] == '0)) ? '1 : '0;
    endcase
`ifdef VGA_BORDER_EN
    if ((h == '0) || (h == 11'(H_ACT - 1)) || (v == '0) || (v == 11'(V_ACT - 1)))
      pix = '1;
`endif
  end

  // Registered video outputs, one strobe behind the counters
  always_ff @(posedge OSC_50) begin
    if (RST) begin
      VGA_HS <= ~HS_ON;
      VGA_VS <= ~VS_ON;
      VGA_DE <= 1'b0;
      X      <= '0;
      Y      <= '0;
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
    end else if (pix_en) begin
      VGA_HS <= hs_in ? HS_ON : ~HS_ON;
      VGA_VS <= vs_in ? VS_ON : ~VS_ON;
      VGA_DE <= active;
      X      <= active ? h : '0;
      Y      <= active ? v : '0;
      {VGA_R, VGA_G, VGA_B} <= active ? pix : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern.sv
// Bench for vga_timing_pattern. Three instances share clock, reset, MODE and
// COLOR: A uses default timing (PIX_DIV=2), B a shrunken raster for
// frame-level behaviour, C default horizontal timing with positive sync
// polarity and PIX_DIV=1. A reference model derives every expected output
// from the pixel index since reset.
module tb_vga_timing_pattern;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [23:0] color = 24'd0;

  logic [2:0]  pe, hs, vs, de;
  logic [10:0] xo [3];
  logic [10:0] yo [3];
  logic [7:0]  ro [3];
  logic [7:0]  go [3];
  logic [7:0]  bo [3];
  logic [15:0] fco [3];

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hpol, vpol;
  } tp_t;

  typedef struct {
    logic hs, vs, de;
    int x, y, fc;
    logic [23:0] rgb;
  } exp_t;

  tp_t tp [3];
  int compared = 0;
  int mismatched = 0;
  int n;
  logic [1:0]  fm;
  logic [23:0] fcol;
  logic [23:0] rec [0:47][0:639];
  int cnt_hs, cnt_vs, cnt_de, hs_lo, hs_hi, vs_lo, vs_hi;

  vga_timing_pattern dut_a (
    .OSC_50(clk), .RST(rst), .MODE(mode), .COLOR(color),
    .PIX_EN(pe[0]), .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_DE(de[0]),
    .X(xo[0]), .Y(yo[0]), .VGA_R(ro[0]), .VGA_G(go[0]), .VGA_B(bo[0]),
    .FRAME_CNT(fco[0]));

  vga_timing_pattern #(
    .H_ACT(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_ACT(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIX_DIV(1)
  ) dut_b (
    .OSC_50(clk), .RST(rst), .MODE(mode), .COLOR(color),
    .PIX_EN(pe[1]), .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_DE(de[1]),
    .X(xo[1]), .Y(yo[1]), .VGA_R(ro[1]), .VGA_G(go[1]), .VGA_B(bo[1]),
    .FRAME_CNT(fco[1]));

  vga_timing_pattern #(
    .V_ACT(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .HS_POL(1), .VS_POL(1), .PIX_DIV(1)
  ) dut_c (
    .OSC_50(clk), .RST(rst), .MODE(mode), .COLOR(color),
    .PIX_EN(pe[2]), .VGA_HS(hs[2]), .VGA_VS(vs[2]), .VGA_DE(de[2]),
    .X(xo[2]), .Y(yo[2]), .VGA_R(ro[2]), .VGA_G(go[2]), .VGA_B(bo[2]),
    .FRAME_CNT(fco[2]));

  // Reference: expected outputs after the update that consumed pixel k
  function automatic exp_t model(input tp_t p, input int k, input logic [1:0] m,
                                 input logic [23:0] c);
    exp_t e;
    int ht, vt, h, v, hb, vb, bi;
    ht = p.ha + p.hf + p.hs + p.hb;
    vt = p.va + p.vf + p.vs + p.vb;
    h  = k % ht;
    v  = (k / ht) % vt;
    hb = p.ha + p.hf;
    vb = p.va + p.vf;
    e.hs  = (h >= hb && h < hb + p.hs) ? p.hpol : ~p.hpol;
    e.vs  = (v >= vb && v < vb + p.vs) ? p.vpol : ~p.vpol;
    e.de  = (h < p.ha) && (v < p.va);
    e.fc  = ((k + 1) / (ht * vt)) % 65536;
    e.x   = 0;
    e.y   = 0;
    e.rgb = 24'h0;
    if (e.de) begin
      e.x = h;
      e.y = v;
      case (m)
        2'd0: e.rgb = c;
        2'd1: begin
          bi = h * 8 / p.ha;
          case (bi)
            0: e.rgb = 24'hFFFFFF;  1: e.rgb = 24'hFFFF00;
            2: e.rgb = 24'h00FFFF;  3: e.rgb = 24'h00FF00;
            4: e.rgb = 24'hFF00FF;  5: e.rgb = 24'hFF0000;
            6: e.rgb = 24'h0000FF;  default: e.rgb = 24'h000000;
          endcase
        end
        2'd2: e.rgb = (((h / 32) + (v / 32)) % 2 == 0) ? c : 24'h0;
        default: e.rgb = (h % 16 == 0 || v % 16 == 0) ? 24'hFFFFFF : 24'h0;
      endcase
`ifdef VGA_BORDER_EN
      if (h == 0 || h == p.ha - 1 || v == 0 || v == p.va - 1) e.rgb = 24'hFFFFFF;
`endif
    end
    return e;
  endfunction

  // Step instance s through cnt pixel updates, checking each against the model
  task automatic sweep(input int s, input int cnt, input int chg_at, input logic [1:0] chg_m,
                       input logic [23:0] chg_c, input bit rnd, input string tag);
    int bad, g, ht, vt, h, v;
    exp_t e;
    string first;
    bad = 0;
    first = "";
    ht = tp[s].ha + tp[s].hf + tp[s].hs + tp[s].hb;
    vt = tp[s].va + tp[s].vf + tp[s].vs + tp[s].vb;
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0;
    hs_lo = 1 << 30; hs_hi = -1; vs_lo = 1 << 30; vs_hi = -1;
    for (int i = 0; i < cnt; i++) begin
      g = 0;
      while (pe[s] !== 1'b1 && g < 4) begin
        @(negedge clk);
        g++;
      end
      if (pe[s] !== 1'b1) begin
        if (bad == 0) first = "pixel strobe never arrived";
        bad++;
        break;
      end
      if (n == chg_at) begin
        mode  = chg_m;
        color = chg_c;
      end
      if (rnd && $urandom_range(0, 199) == 0) begin
        mode  = 2'($urandom_range(0, 3));
        color = 24'($urandom);
      end
      if (n % (ht * vt) == 0) begin
        fm   = mode;
        fcol = color;
      end
      @(posedge clk);
      #1;
      e = model(tp[s], n, fm, fcol);
      h = n % ht;
      v = (n / ht) % vt;
      if (hs[s] !== e.hs || vs[s] !== e.vs || de[s] !== e.de ||
          xo[s] !== 11'(e.x) || yo[s] !== 11'(e.y) ||
          {ro[s], go[s], bo[s]} !== e.rgb || fco[s] !== 16'(e.fc)) begin
        if (bad == 0)
          first = $sformatf("n=%0d got hs%b vs%b de%b x%0d y%0d rgb%h fc%0d want hs%b vs%b de%b x%0d y%0d rgb%h fc%0d",
                            n, hs[s], vs[s], de[s], xo[s], yo[s], {ro[s], go[s], bo[s]}, fco[s],
                            e.hs, e.vs, e.de, e.x, e.y, e.rgb, e.fc);
        bad++;
      end
      if (e.de && v < 48 && h < 640) rec[v][h] = {ro[s], go[s], bo[s]};
      if (hs[s] === tp[s].hpol) begin
        cnt_hs++;
        if (h < hs_lo) hs_lo = h;
        if (h > hs_hi) hs_hi = h;
      end
      if (vs[s] === tp[s].vpol) begin
        cnt_vs++;
        if (v < vs_lo) vs_lo = v;
        if (v > vs_hi) vs_hi = v;
      end
      if (de[s] === 1'b1) cnt_de++;
      n++;
      @(negedge clk);
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL sweep %s: %0d bad pixels (want 0), first %s", tag, bad, first);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    mode  = 2'd2;
    color = 24'hA5A5A5;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      compared++;
      if (de[s] !== 1'b0 || xo[s] !== 11'd0 || yo[s] !== 11'd0) begin
        mismatched++;
        $display("FAIL reset_de_xy[%0d]: got de%b x%0d y%0d want 0 0 0", s, de[s], xo[s], yo[s]);
      end
      compared++;
      if ({ro[s], go[s], bo[s]} !== 24'h0 || fco[s] !== 16'd0) begin
        mismatched++;
        $display("FAIL reset_rgb_fc[%0d]: got rgb%h fc%0d want 0 0", s, {ro[s], go[s], bo[s]}, fco[s]);
      end
      compared++;
      if (hs[s] !== ~tp[s].hpol || vs[s] !== ~tp[s].vpol) begin
        mismatched++;
        $display("FAIL reset_sync[%0d]: got hs%b vs%b want hs%b vs%b", s, hs[s], vs[s], ~tp[s].hpol, ~tp[s].vpol);
      end
    end
    rst = 1'b0;
    n = 0;
    compared++;
    if (pe !== 3'b111) begin
      mismatched++;
      $display("FAIL first_strobe: got %b want 111", pe);
    end
  endtask

  task automatic test_timing_a();
    mode  = 2'd1;
    color = 24'($urandom);
    do_reset();
    sweep(0, 1600, -1, 2'd0, 24'h0, 1'b0, "a_bars");
    compared++;
    if (cnt_hs !== 192 || hs_lo !== 656 || hs_hi !== 751) begin
      mismatched++;
      $display("FAIL a_hsync: got cnt%0d lo%0d hi%0d want 192 656 751", cnt_hs, hs_lo, hs_hi);
    end
    compared++;
    if (cnt_de !== 1280 || cnt_vs !== 0) begin
      mismatched++;
      $display("FAIL a_de_vs: got de%0d vs%0d want 1280 0", cnt_de, cnt_vs);
    end
    compared++;
    if (rec[1][1] !== 24'hFFFFFF || rec[1][79] !== 24'hFFFFFF) begin
      mismatched++;
      $display("FAIL a_bar_white: got %h %h want ffffff", rec[1][1], rec[1][79]);
    end
    compared++;
    if (rec[1][80] !== 24'hFFFF00) begin
      mismatched++;
      $display("FAIL a_bar80: got %h want ffff00", rec[1][80]);
    end
    compared++;
    if (rec[1][400] !== 24'hFF0000) begin
      mismatched++;
      $display("FAIL a_bar400: got %h want ff0000", rec[1][400]);
    end
    compared++;
    if (rec[1][560] !== 24'h000000 || rec[1][638] !== 24'h000000) begin
      mismatched++;
      $display("FAIL a_bar_black: got %h %h want 000000", rec[1][560], rec[1][638]);
    end
  endtask

  task automatic test_random_b();
    mode  = 2'($urandom_range(0, 3));
    color = 24'($urandom);
    do_reset();
    sweep(1, 2 * 4400, -1, 2'd0, 24'h0, 1'b1, "b_random");
    compared++;
    if (cnt_vs !== 320 || vs_lo !== 50 || vs_hi !== 51) begin
      mismatched++;
      $display("FAIL b_vsync: got cnt%0d lo%0d hi%0d want 320 50 51", cnt_vs, vs_lo, vs_hi);
    end
    compared++;
    if (cnt_de !== 6144 || fco[1] !== 16'd2) begin
      mismatched++;
      $display("FAIL b_de_frames: got de%0d fc%0d want 6144 2", cnt_de, fco[1]);
    end
  endtask

  task automatic test_mode_latch_b();
    mode  = 2'd0;
    color = 24'h123456;
    do_reset();
    sweep(1, 4400, 20 * 80, 2'd3, 24'hABCDEF, 1'b0, "b_latch_f1");
    compared++;
    if (rec[10][10] !== 24'h123456 || rec[30][10] !== 24'h123456) begin
      mismatched++;
      $display("FAIL b_latch_hold: got %h %h want 123456", rec[10][10], rec[30][10]);
    end
    sweep(1, 4400, -1, 2'd0, 24'h0, 1'b0, "b_latch_f2");
    compared++;
    if (rec[5][16] !== 24'hFFFFFF || rec[17][17] !== 24'h000000 || rec[30][10] !== 24'h000000) begin
      mismatched++;
      $display("FAIL b_grid: got %h %h %h want ffffff 000000 000000", rec[5][16], rec[17][17], rec[30][10]);
    end
  endtask

  task automatic test_frame_cnt_b();
    mode  = 2'($urandom_range(0, 3));
    color = 24'($urandom);
    do_reset();
    sweep(1, 3 * 4400, -1, 2'd0, 24'h0, 1'b1, "b_fc_frames");
    sweep(1, 20 * 80, -1, 2'd0, 24'h0, 1'b1, "b_fc_partial");
    compared++;
    if (fco[1] !== 16'd3) begin
      mismatched++;
      $display("FAIL b_fc_before: got %0d want 3", fco[1]);
    end
    do_reset();
    compared++;
    if (fco[1] !== 16'd0 || de[1] !== 1'b0) begin
      mismatched++;
      $display("FAIL b_fc_after: got fc%0d de%b want 0 0", fco[1], de[1]);
    end
    sweep(1, 1, -1, 2'd0, 24'h0, 1'b0, "b_fc_first");
    compared++;
    if (de[1] !== 1'b1 || xo[1] !== 11'd0 || yo[1] !== 11'd0) begin
      mismatched++;
      $display("FAIL b_first_de: got de%b x%0d y%0d want 1 0 0", de[1], xo[1], yo[1]);
    end
  endtask

  task automatic test_pol_c();
    int lows;
    mode  = 2'd3;
    color = 24'($urandom);
    do_reset();
    sweep(2, 8000, -1, 2'd0, 24'h0, 1'b1, "c_pol");
    compared++;
    if (cnt_hs !== 960 || hs_lo !== 656 || hs_hi !== 751) begin
      mismatched++;
      $display("FAIL c_hsync: got cnt%0d lo%0d hi%0d want 960 656 751", cnt_hs, hs_lo, hs_hi);
    end
    compared++;
    if (cnt_vs !== 1600 || vs_lo !== 6 || vs_hi !== 7) begin
      mismatched++;
      $display("FAIL c_vsync: got cnt%0d lo%0d hi%0d want 1600 6 7", cnt_vs, vs_lo, vs_hi);
    end
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pe[2] !== 1'b1) lows++;
    end
    n += 50;
    compared++;
    if (lows !== 0) begin
      mismatched++;
      $display("FAIL c_strobe: got %0d low cycles want 0", lows);
    end
  endtask

  task automatic test_border_b();
    logic [23:0] edge_px;
`ifdef VGA_BORDER_EN
    edge_px = 24'hFFFFFF;
`else
    edge_px = 24'h000000;
`endif
    mode  = 2'd0;
    color = 24'h000000;
    do_reset();
    sweep(1, 4400, -1, 2'd0, 24'h0, 1'b0, "b_border");
    compared++;
    if (rec[0][0] !== edge_px || rec[10][63] !== edge_px || rec[47][10] !== edge_px) begin
      mismatched++;
      $display("FAIL b_border_edge: got %h %h %h want %h", rec[0][0], rec[10][63], rec[47][10], edge_px);
    end
    compared++;
    if (rec[1][1] !== 24'h000000) begin
      mismatched++;
      $display("FAIL b_border_inner: got %h want 000000", rec[1][1]);
    end
  endtask

  initial begin
    tp[0] = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:11, vs:2, vb:31, hpol:1'b0, vpol:1'b0};
    tp[1] = '{ha:64,  hf:4,  hs:8,  hb:4,  va:48,  vf:2,  vs:2, vb:3,  hpol:1'b0, vpol:1'b0};
    tp[2] = '{ha:640, hf:16, hs:96, hb:48, va:4,   vf:2,  vs:2, vb:2,  hpol:1'b1, vpol:1'b1};
    test_reset();
    test_timing_a();
    test_random_b();
    test_mode_latch_b();
    test_frame_cnt_b();
    test_pol_c();
    test_border_b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
